// File: rtl/parking_pkg.sv
// Shared types and constants for the parking request front-end.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Upper two bits of the FSM request word {enter, exit}
    localparam logic [1:0] REQ_ENTER = 2'b10;
    localparam logic [1:0] REQ_EXIT  = 2'b01;
    localparam logic [1:0] REQ_NONE  = 2'b00;

    localparam logic [3:0] FULL = 4'hF;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a down-counting debouncer for one bit.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    output logic d_deb
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count down while the synchronised value disagrees; accept it on the last differing sample
    always_comb begin
        sync1_d = d_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = CNT_LOAD;
        if (sync2_q != deb_q) begin
            if (cnt_q == '0) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_deb = deb_q;

endmodule

// File: rtl/parking_request_gen.sv
// Parking request front-end: qualifies sensor edges and feeds single-cycle
// request words to the occupancy FSM, one at a time.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | pick pending exit (priority) or enter; reject if pointless
//   ISSUE    | fsm_in carries the request for exactly this cycle
//   WAIT_ACK | wait for door_open_pulse, give up after ACK_TIMEOUT cycles
//   COOLDOWN | hold off for COOLDOWN_CYCLES before accepting new work
module parking_request_gen
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 8,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_raw,
    input  logic       exit_raw,
    input  logic [1:0] exit_place_raw,
    input  logic [3:0] occupancy,
    input  logic       door_open_pulse,
    output logic [3:0] fsm_in,
    output logic       busy,
    output logic       reject_pulse,
    output logic       timeout_pulse
);

    localparam int TMR_MAX = (ACK_TIMEOUT > COOLDOWN_CYCLES) ? ACK_TIMEOUT : COOLDOWN_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] CD_LOAD  = TMR_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    logic [3:0] raw_vec, deb_vec;
    logic       deb_enter, deb_exit;
    logic [1:0] deb_place;

    assign raw_vec   = {exit_place_raw, exit_raw, enter_raw};
    assign deb_enter = deb_vec[0];
    assign deb_exit  = deb_vec[1];
    assign deb_place = deb_vec[3:2];

    for (genvar i = 0; i < 4; i++) begin : g_deb
        sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (reset),
            .d_raw (raw_vec[i]),
            .d_deb (deb_vec[i])
        );
    end

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             enter_prev_q, enter_prev_d;
    logic             exit_prev_q, exit_prev_d;
    logic             enter_rise_q, enter_rise_d;
    logic             exit_rise_q, exit_rise_d;
    logic             pend_enter_q, pend_enter_d;
    logic             pend_exit_q, pend_exit_d;
    logic [1:0]       pend_place_q, pend_place_d;
    logic [3:0]       fsm_in_q, fsm_in_d;
    logic             busy_q, busy_d;
    logic             reject_q, reject_d;
    logic             timeout_q, timeout_d;
    logic             clr_enter, clr_exit;

    // Edge capture, pending flags and request sequencing
    always_comb begin
        enter_prev_d = deb_enter;
        exit_prev_d  = deb_exit;
        enter_rise_d = deb_enter & ~enter_prev_q;
        exit_rise_d  = deb_exit & ~exit_prev_q;
        state_d      = state_q;
        tmr_d        = tmr_q;
        fsm_in_d     = {REQ_NONE, 2'b00};
        reject_d     = 1'b0;
        timeout_d    = 1'b0;
        clr_enter    = 1'b0;
        clr_exit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_exit_q) begin
                    if (!occupancy[pend_place_q]) begin
                        reject_d = 1'b1;
                        clr_exit = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        fsm_in_d = {REQ_EXIT, pend_place_q};
                    end
                end else if (pend_enter_q) begin
                    if (occupancy == FULL) begin
                        reject_d  = 1'b1;
                        clr_enter = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        fsm_in_d = {REQ_ENTER, 2'b00};
                    end
                end
            end
            ISSUE: begin
                // The word being presented tells which request is consumed
                clr_enter = fsm_in_q[3];
                clr_exit  = fsm_in_q[2];
                state_d   = WAIT_ACK;
                tmr_d     = ACK_LOAD;
            end
            WAIT_ACK: begin
                if (door_open_pulse || tmr_q == '0) begin
                    timeout_d = ~door_open_pulse;
                    state_d   = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
                    tmr_d     = CD_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            COOLDOWN: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pend_enter_d = (pend_enter_q & ~clr_enter) | enter_rise_q;
        pend_exit_d  = (pend_exit_q & ~clr_exit) | exit_rise_q;
        // A pending exit keeps its place; later exit edges are absorbed
        if (exit_rise_q && (!pend_exit_q || clr_exit)) begin
            pend_place_d = deb_place;
        end else begin
            pend_place_d = pend_place_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            enter_prev_q <= 1'b0;
            exit_prev_q  <= 1'b0;
            enter_rise_q <= 1'b0;
            exit_rise_q  <= 1'b0;
            pend_enter_q <= 1'b0;
            pend_exit_q  <= 1'b0;
            pend_place_q <= 2'b00;
            fsm_in_q     <= 4'b0000;
            busy_q       <= 1'b0;
            reject_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            enter_prev_q <= enter_prev_d;
            exit_prev_q  <= exit_prev_d;
            enter_rise_q <= enter_rise_d;
            exit_rise_q  <= exit_rise_d;
            pend_enter_q <= pend_enter_d;
            pend_exit_q  <= pend_exit_d;
            pend_place_q <= pend_place_d;
            fsm_in_q     <= fsm_in_d;
            busy_q       <= busy_d;
            reject_q     <= reject_d;
            timeout_q    <= timeout_d;
        end
    end

    assign fsm_in        = fsm_in_q;
    assign busy          = busy_q;
    assign reject_pulse  = reject_q;
    assign timeout_pulse = timeout_q;

endmodule
